// File: rtl/t5_dwb_ctl.sv
// Data-side Wishbone sequencer for the tra5 barrel pipeline: X-stage load/store decode,
// byte-lane steering, one classic bus cycle per access, stall generation and fault reporting.
module t5_dwb_ctl #(
    parameter int XLEN = 32,
    parameter int TMO  = 15
) (
    input  logic            sclk,
    input  logic            srst,
    input  logic            ext_ena,
    input  logic            xvld,
    input  logic [6:2]      xopc,
    input  logic [14:12]    xfn3,
    input  logic [XLEN-1:0] xadr,
    input  logic [XLEN-1:0] xdat,
    input  logic [1:0]      xhart,
    input  logic            dwb_ack,
    input  logic [XLEN-1:0] dwb_dti,
    output logic [XLEN-1:0] dwb_adr,
    output logic [XLEN-1:0] dwb_dto,
    output logic [3:0]      dwb_sel,
    output logic            dwb_stb,
    output logic            dwb_cyc,
    output logic            dwb_wre,
    output logic            sena,
    output logic [3:0]      xsel,
    output logic            xstb,
    output logic            xwre,
    output logic [XLEN-1:0] mdti,
    output logic            fault,
    output logic [1:0]      fhart,
    output logic            fcause,
    output logic [1:0]      dbg_state
);

    // Wishbone handshake: a cycle is open while stb=cyc=1; the slave ends it with a
    // one-cycle dwb_ack; with no ack after TMO WAIT cycles the cycle is abandoned.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [7:0]      tmo_cnt;
    logic [1:0]      hart_q;
    logic            is_load;
    logic            is_store;
    logic            mem;
    logic            mis;
    logic [3:0]      lane_sel;
    logic [XLEN-1:0] lane_dto;
    logic            issue;
    logic            mis_fault;
    logic            stall;
    logic            tmo_hit;
    logic            unused_fn3;

    assign unused_fn3 = xfn3[14];
    assign is_load    = (xopc == 5'b00000);
    assign is_store   = (xopc == 5'b01000);
    assign mem        = xvld & (is_load | is_store);

    always_comb begin
        lane_sel = 4'h0;
        lane_dto = xdat;
        mis      = 1'b1;
        case (xfn3[13:12])
            2'b00: begin
                lane_sel = 4'b0001 << xadr[1:0];
                lane_dto = {4{xdat[7:0]}};
                mis      = 1'b0;
            end
            2'b01: begin
                lane_sel = xadr[1] ? 4'hC : 4'h3;
                lane_dto = {2{xdat[15:0]}};
                mis      = xadr[0];
            end
            2'b10: begin
                lane_sel = 4'hF;
                lane_dto = xdat;
                mis      = |xadr[1:0];
            end
            default: mis = 1'b1;
        endcase
    end

    assign issue     = mem & ~mis & ext_ena;
    assign mis_fault = mem & mis & ext_ena;
    assign tmo_hit   = (tmo_cnt == 8'(TMO - 1));
    assign stall     = ((state == S_IDLE) & issue) | (state == S_WAIT);
    assign sena      = ext_ena & ~stall;
    assign dbg_state = state;

    always_ff @(posedge sclk) begin
        if (srst) begin
            state   <= S_IDLE;
            tmo_cnt <= 8'd0;
            hart_q  <= 2'd0;
            dwb_adr <= '0;
            dwb_dto <= '0;
            dwb_sel <= 4'h0;
            dwb_stb <= 1'b0;
            dwb_cyc <= 1'b0;
            dwb_wre <= 1'b0;
            xsel    <= 4'h0;
            xstb    <= 1'b0;
            xwre    <= 1'b0;
            mdti    <= '0;
            fault   <= 1'b0;
            fhart   <= 2'd0;
            fcause  <= 1'b0;
        end else begin
            fault <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        dwb_adr <= {xadr[XLEN-1:2], 2'b00};
                        dwb_sel <= lane_sel;
                        dwb_dto <= lane_dto;
                        dwb_wre <= is_store;
                        dwb_stb <= 1'b1;
                        dwb_cyc <= 1'b1;
                        tmo_cnt <= 8'd0;
                        hart_q  <= xhart;
                        state   <= S_WAIT;
                    end else if (mis_fault) begin
                        fault  <= 1'b1;
                        fcause <= 1'b0;
                        fhart  <= xhart;
                    end
                end
                S_WAIT: begin
                    if (dwb_ack) begin
                        mdti    <= dwb_dti;
                        xsel    <= dwb_sel;
                        xwre    <= dwb_wre;
                        dwb_stb <= 1'b0;
                        dwb_cyc <= 1'b0;
                        xstb    <= 1'b1;
                        state   <= S_DONE;
                    end else if (tmo_hit) begin
                        // Abandoned access: no data, back stage drops it on the fault pulse.
                        mdti    <= '0;
                        xsel    <= 4'h0;
                        xwre    <= 1'b0;
                        dwb_stb <= 1'b0;
                        dwb_cyc <= 1'b0;
                        fault   <= 1'b1;
                        fcause  <= 1'b1;
                        fhart   <= hart_q;
                        xstb    <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    if (ext_ena) begin
                        xstb  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_t5_dwb_ctl.sv
// Randomised and directed bench for t5_dwb_ctl against a transaction-level model of the
// data-side Wishbone sequencer.
module tb_t5_dwb_ctl;

    localparam int TMO = 15;

    logic        sclk;
    logic        srst;
    logic        ext_ena;
    logic        xvld;
    logic [4:0]  xopc;
    logic [2:0]  xfn3;
    logic [31:0] xadr;
    logic [31:0] xdat;
    logic [1:0]  xhart;
    logic        dwb_ack;
    logic [31:0] dwb_dti;
    logic [31:0] dwb_adr;
    logic [31:0] dwb_dto;
    logic [3:0]  dwb_sel;
    logic        dwb_stb;
    logic        dwb_cyc;
    logic        dwb_wre;
    logic        sena;
    logic [3:0]  xsel;
    logic        xstb;
    logic        xwre;
    logic [31:0] mdti;
    logic        fault;
    logic [1:0]  fhart;
    logic        fcause;
    logic [1:0]  unused_dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    t5_dwb_ctl #(.XLEN(32), .TMO(TMO)) dut (
        .sclk(sclk), .srst(srst), .ext_ena(ext_ena), .xvld(xvld), .xopc(xopc),
        .xfn3(xfn3), .xadr(xadr), .xdat(xdat), .xhart(xhart), .dwb_ack(dwb_ack),
        .dwb_dti(dwb_dti), .dwb_adr(dwb_adr), .dwb_dto(dwb_dto), .dwb_sel(dwb_sel),
        .dwb_stb(dwb_stb), .dwb_cyc(dwb_cyc), .dwb_wre(dwb_wre), .sena(sena),
        .xsel(xsel), .xstb(xstb), .xwre(xwre), .mdti(mdti), .fault(fault),
        .fhart(fhart), .fcause(fcause), .dbg_state(unused_dbg_state)
    );

    // clock / reset
    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit f_mem(input bit v, input logic [4:0] opc);
        return v && (opc == 5'd0 || opc == 5'd8);
    endfunction

    function automatic int f_bytes(input logic [2:0] fn3);
        return 1 << fn3[1:0];
    endfunction

    function automatic bit f_mis(input logic [2:0] fn3, input logic [31:0] a);
        if (fn3[1:0] == 2'b11) return 1'b1;
        return (a % f_bytes(fn3)) != 0;
    endfunction

    function automatic logic [3:0] f_sel(input logic [2:0] fn3, input logic [31:0] a);
        int n;
        n = f_bytes(fn3);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] f_dto(input logic [2:0] fn3, input logic [31:0] d);
        if (fn3[1:0] == 2'b00) return (d & 32'hFF) * 32'h01010101;
        if (fn3[1:0] == 2'b01) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    bit          m_busy, m_done, m_tmo, m_fault, m_wre, m_xwre, m_fcause;
    int          m_wait;
    logic [31:0] m_adr, m_dto, m_mdti;
    logic [3:0]  m_sel, m_xsel;
    logic [1:0]  m_hart, m_fhart;

    always @(posedge sclk) begin
        if (srst) begin
            m_busy = 0; m_done = 0; m_tmo = 0; m_fault = 0; m_wait = 0;
            m_adr = 0; m_dto = 0; m_sel = 0; m_wre = 0; m_hart = 0;
            m_mdti = 0; m_xsel = 0; m_xwre = 0; m_fhart = 0; m_fcause = 0;
        end else begin
            m_fault = 0;
            if (m_done) begin
                if (ext_ena) m_done = 0;
            end else if (m_busy) begin
                if (dwb_ack) begin
                    m_mdti = dwb_dti; m_xsel = m_sel; m_xwre = m_wre;
                    m_busy = 0; m_done = 1; m_tmo = 0;
                end else if (m_wait + 1 == TMO) begin
                    m_mdti = 0; m_busy = 0; m_done = 1; m_tmo = 1;
                    m_fault = 1; m_fcause = 1; m_fhart = m_hart;
                end else begin
                    m_wait++;
                end
            end else if (f_mem(xvld, xopc) && ext_ena) begin
                if (f_mis(xfn3, xadr)) begin
                    m_fault = 1; m_fcause = 0; m_fhart = xhart;
                end else begin
                    m_busy = 1; m_wait = 0;
                    m_adr = xadr & ~32'd3; m_sel = f_sel(xfn3, xadr);
                    m_dto = f_dto(xfn3, xdat); m_wre = (xopc == 5'd8); m_hart = xhart;
                end
            end
        end
    end

    // scoreboard compare, on the falling edge
    always @(negedge sclk) begin
        bit issuing;
        if (chk_en) begin
            issuing = !m_busy && !m_done && f_mem(xvld, xopc) && !f_mis(xfn3, xadr) && ext_ena;
            chk("stb", 32'(dwb_stb), 32'(m_busy));
            chk("cyc", 32'(dwb_cyc), 32'(m_busy));
            chk("xstb", 32'(xstb), 32'(m_done));
            chk("fault", 32'(fault), 32'(m_fault));
            chk("sena", 32'(sena), 32'(ext_ena && !(m_busy || issuing)));
            chk("mdti", mdti, m_mdti);
            if (m_busy) begin
                chk("adr", dwb_adr, m_adr);
                chk("sel", 32'(dwb_sel), 32'(m_sel));
                chk("dto", dwb_dto, m_dto);
                chk("wre", 32'(dwb_wre), 32'(m_wre));
            end
            if (!m_tmo) begin
                chk("xsel", 32'(xsel), 32'(m_xsel));
                chk("xwre", 32'(xwre), 32'(m_xwre));
            end
            if (m_fault) begin
                chk("fhart", 32'(fhart), 32'(m_fhart));
                chk("fcause", 32'(fcause), 32'(m_fcause));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        ext_ena = 1; xvld = 0; xopc = 5'h1F; xfn3 = 0; xadr = 0; xdat = 0;
        xhart = 0; dwb_ack = 0; dwb_dti = 0;
    endtask

    task automatic access(input logic [4:0] opc, input logic [2:0] fn3,
                          input logic [31:0] adr, input logic [31:0] dat,
                          input logic [1:0] hart, input int ack_at, input int hold,
                          input logic [31:0] rdat,
                          output int stb_n, output int sena_lo, output int fault_n,
                          output logic [31:0] adr_s, output logic [3:0] sel_s,
                          output logic [31:0] dto_s, output logic wre_s,
                          output logic [31:0] mdti_s, output logic [3:0] xsel_s,
                          output logic xwre_s, output logic fcause_s,
                          output logic [1:0] fhart_s, output logic post_stb);
        int w, hcnt;
        bit done;
        w = 0; hcnt = hold; done = 0;
        stb_n = 0; sena_lo = 0; fault_n = 0;
        adr_s = 0; sel_s = 0; dto_s = 0; wre_s = 0; mdti_s = 0; xsel_s = 0;
        xwre_s = 0; fcause_s = 0; fhart_s = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge sclk); #1;
            if (c == 0) begin
                xvld = 1; xopc = opc; xfn3 = fn3; xadr = adr; xdat = dat; xhart = hart;
                ext_ena = 1;
            end
            dwb_ack = 0;
            if (dwb_stb) begin
                w++;
                if (w == ack_at) begin
                    dwb_ack = 1; dwb_dti = rdat;
                    if (hcnt > 0) ext_ena = 0;
                end
            end
            if (xstb) begin
                if (hcnt > 0) begin hcnt--; ext_ena = 0; end
                else ext_ena = 1;
            end
            #1;
            if (dwb_stb) begin
                stb_n++; adr_s = dwb_adr; sel_s = dwb_sel; dto_s = dwb_dto; wre_s = dwb_wre;
            end
            if (!sena) sena_lo++;
            if (fault) begin fault_n++; fcause_s = fcause; fhart_s = fhart; end
            if (xstb) begin mdti_s = mdti; xsel_s = xsel; xwre_s = xwre; end
            if (sena) done = 1;
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL access_bound: got no pipeline advance expected advance within 60 cycles");
        end
        @(posedge sclk); #1;
        idle_inputs();
        #1;
        if (fault) begin fault_n++; fcause_s = fcause; fhart_s = fhart; end
        post_stb = dwb_stb;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int sn, sl, fn, mode;
        logic [31:0] as, ds, ms;
        logic [3:0]  ss, xs;
        logic        ws, xw, fc, ps;
        logic [1:0]  fh;
        int r;

        idle_inputs();
        srst = 1;
        chk_en = 1;
        repeat (2) @(posedge sclk);
        #1 srst = 0;
        #1;
        chk("rst_stb", 32'(dwb_stb), 0);
        chk("rst_cyc", 32'(dwb_cyc), 0);
        chk("rst_adr", dwb_adr, 0);
        chk("rst_dto", dwb_dto, 0);
        chk("rst_sel", 32'(dwb_sel), 0);
        chk("rst_wre", 32'(dwb_wre), 0);
        chk("rst_xsel", 32'(xsel), 0);
        chk("rst_xstb", 32'(xstb), 0);
        chk("rst_xwre", 32'(xwre), 0);
        chk("rst_mdti", mdti, 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_fhart", 32'(fhart), 0);
        chk("rst_fcause", 32'(fcause), 0);
        chk("rst_sena", 32'(sena), 1);

        // aligned word load, ack in the second WAIT cycle
        access(5'b00000, 3'b010, 32'h104, 32'h0, 2'd1, 2, 0, 32'hDEADBEEF,
               sn, sl, fn, as, ss, ds, ws, ms, xs, xw, fc, fh, ps);
        chk("t1_adr", as, 32'h104);
        chk("t1_sel", 32'(ss), 32'hF);
        chk("t1_stb_cycles", sn, 2);
        chk("t1_sena_low", sl, 3);
        chk("t1_mdti", ms, 32'hDEADBEEF);
        chk("t1_xsel", 32'(xs), 32'hF);
        chk("t1_wre", 32'(ws), 0);

        // byte store to lane 3, ack in the first WAIT cycle
        access(5'b01000, 3'b000, 32'h203, 32'h000000A5, 2'd0, 1, 0, 32'h0,
               sn, sl, fn, as, ss, ds, ws, ms, xs, xw, fc, fh, ps);
        chk("t2_sel", 32'(ss), 32'h8);
        chk("t2_dto", ds, 32'hA5A5A5A5);
        chk("t2_wre", 32'(ws), 1);
        chk("t2_xwre", 32'(xw), 1);
        chk("t2_adr", as, 32'h200);

        // misaligned half load
        access(5'b00000, 3'b001, 32'h101, 32'h0, 2'd2, 1, 0, 32'h0,
               sn, sl, fn, as, ss, ds, ws, ms, xs, xw, fc, fh, ps);
        chk("t3_stb_cycles", sn, 0);
        chk("t3_sena_low", sl, 0);
        chk("t3_fault_pulses", fn, 1);
        chk("t3_fcause", 32'(fc), 0);
        chk("t3_fhart", 32'(fh), 2);

        // word load that never gets an ack
        access(5'b00000, 3'b010, 32'h300, 32'h0, 2'd3, 0, 0, 32'h0,
               sn, sl, fn, as, ss, ds, ws, ms, xs, xw, fc, fh, ps);
        chk("t4_stb_cycles", sn, TMO);
        chk("t4_sena_low", sl, TMO + 1);
        chk("t4_fault_pulses", fn, 1);
        chk("t4_fcause", 32'(fc), 1);
        chk("t4_fhart", 32'(fh), 3);
        chk("t4_mdti", ms, 0);
        chk("t4_post_stb", 32'(ps), 0);

        // ack while the pipeline is held off for four cycles
        access(5'b00000, 3'b010, 32'h40, 32'h0, 2'd1, 1, 4, 32'h12345678,
               sn, sl, fn, as, ss, ds, ws, ms, xs, xw, fc, fh, ps);
        chk("t5_stb_cycles", sn, 1);
        chk("t5_sena_low", sl, 6);
        chk("t5_mdti", ms, 32'h12345678);
        chk("t5_post_stb", 32'(ps), 0);

        // reset during the second WAIT cycle
        @(posedge sclk); #1;
        xvld = 1; xopc = 5'b00000; xfn3 = 3'b010; xadr = 32'h80;
        @(posedge sclk); #1;
        @(posedge sclk); #1;
        srst = 1;
        @(posedge sclk); #1;
        srst = 0;
        idle_inputs();
        #1;
        chk("t6_stb", 32'(dwb_stb), 0);
        chk("t6_cyc", 32'(dwb_cyc), 0);
        chk("t6_sel", 32'(dwb_sel), 0);
        chk("t6_wre", 32'(dwb_wre), 0);
        chk("t6_fault", 32'(fault), 0);
        chk("t6_mdti", mdti, 0);
        chk("t6_sena", 32'(sena), 1);
        access(5'b01000, 3'b001, 32'h502, 32'h0000BEEF, 2'd0, 3, 0, 32'h0,
               sn, sl, fn, as, ss, ds, ws, ms, xs, xw, fc, fh, ps);
        chk("t6_after_sel", 32'(ss), 32'hC);
        chk("t6_after_dto", ds, 32'hBEEFBEEF);
        chk("t6_after_stb_cycles", sn, 3);

        // randomised traffic
        mode = 2;
        for (int c = 0; c < 4000; c++) begin
            @(posedge sclk); #1;
            if (c % 64 == 0) mode = $urandom_range(0, 2);
            srst    = ($urandom_range(0, 299) == 0);
            ext_ena = ($urandom_range(0, 3) != 0);
            xvld    = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 3);
            xopc  = (r == 1) ? 5'b01000 : (r == 2) ? 5'($urandom) : 5'b00000;
            xfn3  = 3'($urandom);
            xadr  = $urandom;
            xdat  = $urandom;
            xhart = 2'($urandom);
            dwb_dti = $urandom;
            dwb_ack = (mode == 0) ? 1'b0 :
                      (mode == 1) ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
        end
        @(posedge sclk); #1;
        srst = 0;
        idle_inputs();
        repeat (3) @(posedge sclk);
        #1;
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/t5_dwb_ctl.md
Name: t5_dwb_ctl

Overview:
- Data-side Wishbone sequencer for the tra5 barrel pipeline.
- Decodes load/store in the X stage, computes byte lanes and store-data steering, and runs one Wishbone classic cycle per access.
- Stalls the whole pipeline through sena until the access completes, and hands captured read data plus lane select to the back (M/writeback) stage.
- Also flags misaligned accesses and bus timeouts per hart.

Parameters:
XLEN, 32, datapath width (only 32 supported)
TMO, 15, max wait cycles for dwb_ack before timeout (1..255)

Ports:
sclk  in  1  clock
srst  in  1  synchronous active-high reset
ext_ena  in  1  global pipeline enable from other stall sources
xvld  in  1  X-stage instruction valid
xopc  in  5 [6:2]  X-stage opcode
xfn3  in  3 [14:12]  X-stage funct3
xadr  in  XLEN  effective address from ALU
xdat  in  XLEN  rs2 store data
xhart  in  2  hart id of X-stage instruction
dwb_ack  in  1  Wishbone acknowledge
dwb_dti  in  XLEN  Wishbone read data
dwb_adr  out  XLEN  word address, [1:0] forced 0
dwb_dto  out  XLEN  lane-steered write data
dwb_sel  out  4  byte lanes
dwb_stb  out  1  strobe
dwb_cyc  out  1  cycle
dwb_wre  out  1  write enable
sena  out  1  pipeline enable = ext_ena & !stall
xsel  out  4  lane select to back stage, held with read data
xstb  out  1  access-completed marker to back stage
xwre  out  1  completed access was a store
mdti  out  XLEN  captured read data to back stage
fault  out  1  one-cycle pulse: misaligned or timeout
fhart  out  2  hart of faulting access
fcause  out  1  0 = misaligned, 1 = timeout

Behaviour:
- Decode: load = xopc==5'b00000; store = xopc==5'b01000; mem = xvld & (load|store).
- Size from xfn3[13:12]:
  - 00 byte: sel = 4'b0001<<xadr[1:0]; dto = {4{xdat[7:0]}}.
  - 01 half: sel = xadr[1] ? 4'hC : 4'h3; dto = {2{xdat[15:0]}}; misaligned if xadr[0].
  - 10 word: sel = 4'hF; dto = xdat; misaligned if xadr[1:0]!=0.
  - 11: treated as misaligned.
- FSM states IDLE, WAIT, DONE. Reset state IDLE.
- IDLE:
  - mem & aligned & ext_ena -> register adr/sel/dto/wre, raise stb=cyc next edge, go WAIT; internal stall=1 this cycle.
  - mem & misaligned & ext_ena -> no bus cycle; fault=1, fcause=0, fhart=xhart for one cycle; stall=0 (instruction retires, back stage suppresses via fault).
  - Otherwise stall=0.
- WAIT: stb/cyc/adr/sel/dto/wre stable; stall=1; timeout counter increments each cycle.
  - dwb_ack -> capture mdti<=dwb_dti, xsel<=dwb_sel, xwre<=dwb_wre, drop stb/cyc next edge, go DONE.
  - No ack after TMO cycles in WAIT -> drop stb/cyc, fault=1, fcause=1, fhart=latched hart, mdti<=0, go DONE.
- DONE: stall=0, xstb=1.
  - Remain in DONE while ext_ena=0; mdti, xsel and xwre are held.
  - When ext_ena=1 (pipeline advances), go IDLE.
  - The X-stage op seen in this cycle is already serviced and is not re-issued.
- Minimum access cost: 3 cycles (IDLE issue, WAIT with ack, DONE advance).
- stb and cyc are always equal. No pipelined or burst Wishbone; a single outstanding access.
- An ack in any state other than WAIT is ignored.
- Reset mid-access: at the next edge stb=cyc=wre=0, sel=0, state IDLE, counter 0, no fault.
- Reset values: dwb_adr=0, dwb_dto=0, dwb_sel=0, dwb_stb=0, dwb_cyc=0, dwb_wre=0, xsel=0, xstb=0, xwre=0, mdti=0, fault=0, fhart=0, fcause=0. sena follows ext_ena (stall=0).

Test Plan:
- Aligned word load at xadr=0x104, ack after 2 WAIT cycles with dwb_dti=0xDEADBEEF -> dwb_adr=0x104, dwb_sel=F, stb for exactly 2 cycles, sena low for 3 cycles, then mdti=0xDEADBEEF, xstb=1, xsel=F.
- Byte store at 0x203, xdat=0x000000A5, ack in the first WAIT cycle -> dwb_sel=8, dwb_dto=0xA5A5A5A5, dwb_wre=1, xwre=1 in DONE.
- Half load at 0x101 -> no stb, fault pulse with fcause=0, fhart=xhart, sena never drops.
- Word load with no ack, TMO=15 -> stb high for 15 cycles, then fault with fcause=1, stb=0, DONE, pipeline resumes.
- Ack arrives while ext_ena=0, hold off for 4 cycles -> mdti held, sena=0 until ext_ena=1, single advance, no re-issue.
- srst asserted in the 2nd WAIT cycle -> stb/cyc=0 at the next edge, all outputs at reset values, a later access works normally.
